// File: rtl/rv_lsu_pkg.sv
// Shared definitions for the rv_lsu load/store unit: funct3 codes, FSM states
// and the store byte-strobe helper.
package rv_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  // size is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic [3:0] wstrb_f(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/rv_lsu_if.sv
// Core-request, response and memory-port signals of the rv_lsu, bundled with
// a slave view for the LSU and a master view for whatever drives it.
interface rv_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_write;
  logic        mem_addr_ready;
  logic [31:0] mem_rdata;
  logic        mem_data_ready;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  mem_rdata, mem_data_ready,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_wstrb, mem_write, mem_addr_ready
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    output mem_rdata, mem_data_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_wstrb, mem_write, mem_addr_ready
  );

endinterface

// File: rtl/rv_lsu_load_align.sv
// Picks the addressed byte/half/word out of a memory word and sign- or
// zero-extends it according to the load funct3.
module rv_lsu_load_align
  import rv_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{off_i, 3'b000} +: 8];
  assign half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {24'h0, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {16'h0, half_sel};
      F3_LW:   data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/rv_lsu.sv
// RV32I load/store unit: IDLE -> ISSUE -> WAIT with a bounded wait and
// registered outputs. Define RV_LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic     clk,
  input  logic     rst,
  rv_lsu_if.slave  bus
);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wstrb_q;
  logic        mem_write_q;
  logic        mem_addr_ready_q;

  logic        illegal;
  logic        misalign;
  logic [1:0]  size;
  logic [1:0]  off;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  assign size = bus.req_funct3[1:0];

  always_comb begin
    illegal = bus.req_write ? (bus.req_funct3 > F3_SW)
                            : (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11);
`ifdef RV_LSU_MISALIGN_TRAP_EN
    misalign = (size == 2'b01 && bus.req_addr[0]) ||
               (size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    off      = bus.req_addr[1:0];
`else
    // Without the trap, misaligned halves/words silently drop the low bits.
    misalign = 1'b0;
    off      = (size == 2'b01) ? {bus.req_addr[1], 1'b0} :
               (size == 2'b10) ? 2'b00 : bus.req_addr[1:0];
`endif
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign st_data[8*gi +: 8] =
      (bus.req_funct3 == F3_SB) ? bus.req_wdata[7:0] :
      (bus.req_funct3 == F3_SH) ? bus.req_wdata[8*(gi%2) +: 8] :
                                  bus.req_wdata[8*gi +: 8];
  end

  rv_lsu_load_align u_align (
    .rdata_i  (bus.mem_rdata),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .data_o   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      write_q          <= 1'b0;
      funct3_q         <= '0;
      off_q            <= '0;
      req_ready_q      <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      resp_rdata_q     <= '0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_wstrb_q      <= '0;
      mem_write_q      <= 1'b0;
      mem_addr_ready_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            if (illegal || misalign) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q          <= ST_ISSUE;
              req_ready_q      <= 1'b0;
              write_q          <= bus.req_write;
              funct3_q         <= bus.req_funct3;
              off_q            <= off;
              cnt_q            <= '0;
              mem_addr_q       <= {bus.req_addr[31:2], 2'b00};
              mem_wdata_q      <= bus.req_write ? st_data : 32'h0;
              mem_wstrb_q      <= bus.req_write ? wstrb_f(size, off) : 4'b0000;
              mem_write_q      <= bus.req_write;
              mem_addr_ready_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          state_q          <= ST_WAIT;
          mem_addr_ready_q <= 1'b0;
          mem_write_q      <= 1'b0;
          mem_wstrb_q      <= 4'b0000;
        end
        ST_WAIT: begin
          // A completion on the last allowed cycle still wins over the timeout.
          if (bus.mem_data_ready) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= write_q ? 32'h0 : ld_data;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.resp_err       = resp_err_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_wstrb      = mem_wstrb_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_addr_ready = mem_addr_ready_q;

endmodule
